// File: rtl/column_line_buffer_pkg.sv
// Shared types and constants for the column line buffer
// and the theta-to-column mapper that feeds it.
package linebuf_pkg;

   localparam int LED_COUNT   = 52;
   localparam int PX_IDX_W    = 6;
   localparam int TEX_WIDTH   = 256;
   localparam int COL_W       = 8;
   localparam int ADDR_W      = 20;
   localparam int DATA_W      = 24;
   localparam int ROM_LATENCY = 1;

   localparam logic [DATA_W-1:0] OFF_PIXEL = 24'h000000;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      READY
   } lb_state_e;

   // Word address of pixel idx of column col inside frame base.
   function automatic logic [ADDR_W-1:0] tex_addr(
      input logic [ADDR_W-1:0]   base,
      input logic [COL_W-1:0]    col,
      input logic [PX_IDX_W-1:0] idx
   );
      return base + (ADDR_W'(idx) << COL_W) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/column_line_buffer_if.sv
// Texture ROM, strip-driver and status signals of the line buffer.
// LINEBUF_STATS_EN adds the swap/stale counters.
interface column_line_buffer_if;
   import linebuf_pkg::*;

   logic [COL_W-1:0]    col_in;
   logic [ADDR_W-1:0]   frame_base;
   logic [ADDR_W-1:0]   rom_addr;
   logic [DATA_W-1:0]   rom_data;
   logic [PX_IDX_W-1:0] px_idx;
   logic [DATA_W-1:0]   px_data;
   logic                strip_sync;
   logic                front_valid;
   logic                busy;
`ifdef LINEBUF_STATS_EN
   logic [15:0]         swap_count;
   logic [15:0]         stale_count;

   modport master (
      output col_in, frame_base, rom_data, px_idx, strip_sync,
      input  rom_addr, px_data, front_valid, busy,
      input  swap_count, stale_count
   );
   modport slave (
      input  col_in, frame_base, rom_data, px_idx, strip_sync,
      output rom_addr, px_data, front_valid, busy,
      output swap_count, stale_count
   );
`else
   modport master (
      output col_in, frame_base, rom_data, px_idx, strip_sync,
      input  rom_addr, px_data, front_valid, busy
   );
   modport slave (
      input  col_in, frame_base, rom_data, px_idx, strip_sync,
      output rom_addr, px_data, front_valid, busy
   );
`endif

endinterface

// File: rtl/column_line_buffer_bank_ram.sv
// Two LED_COUNT x DATA_W banks: write into one bank,
// registered read from the other.
module linebuf_bank_ram
   import linebuf_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we_i,
   input  logic                wbank_i,
   input  logic [PX_IDX_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                rbank_i,
   input  logic [PX_IDX_W-1:0] raddr_i,
   input  logic                ren_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] mem_q [2][LED_COUNT];
   logic [DATA_W-1:0] rdata_q;

   // No reset on the array so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[wbank_i][waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rdata_q <= OFF_PIXEL;
      else if (ren_i)
         rdata_q <= mem_q[rbank_i][raddr_i];
      else
         rdata_q <= OFF_PIXEL;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/column_line_buffer.sv
// Double-buffered texture column cache feeding the strip driver.
// LINEBUF_STATS_EN adds saturating swap/stale counters.
module column_line_buffer
   import linebuf_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   column_line_buffer_if.slave  bus
);

   lb_state_e state_q, state_d;

   logic [COL_W-1:0]    tgt_col_q, ld_col_q;
   logic [ADDR_W-1:0]   tgt_base_q, ld_base_q;
   logic [PX_IDX_W-1:0] i_q, i_d;
   logic                sel_q, fv_q;

   logic [ROM_LATENCY-1:0] tag_v_q;
   logic [PX_IDX_W-1:0]    tag_idx_q [ROM_LATENCY];

   logic new_req, tgt_diff, last_issue, drain_done;
   logic load_tgt, issue, swap;

   assign new_req    = (bus.col_in != ld_col_q) ||
                       (bus.frame_base != ld_base_q);
   assign tgt_diff   = (bus.col_in != tgt_col_q) ||
                       (bus.frame_base != tgt_base_q);
   assign last_issue = (i_q == PX_IDX_W'(LED_COUNT - 1));
   assign drain_done = (i_q == PX_IDX_W'(ROM_LATENCY - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (new_req) state_d = FILL;
         FILL:  if (last_issue) state_d = DRAIN;
         DRAIN: if (drain_done) state_d = READY;
         READY: begin
            // A swap takes priority; IDLE re-evaluates the inputs.
            if (bus.strip_sync)
               state_d = IDLE;
            else if (tgt_diff)
               state_d = FILL;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_tgt     = 1'b0;
      issue        = 1'b0;
      swap         = 1'b0;
      i_d          = i_q;
      bus.rom_addr = '0;
      unique case (state_q)
         IDLE: begin
            load_tgt = new_req;
            if (new_req) i_d = '0;
         end
         FILL: begin
            issue        = 1'b1;
            bus.rom_addr = tex_addr(tgt_base_q, tgt_col_q, i_q);
            i_d          = last_issue ? '0 : i_q + 1'b1;
         end
         DRAIN: i_d = i_q + 1'b1;
         READY: begin
            swap     = bus.strip_sync;
            load_tgt = !bus.strip_sync && tgt_diff;
            if (load_tgt) i_d = '0;
         end
         default: ;
      endcase
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.front_valid = fv_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tgt_col_q  <= '1;
         tgt_base_q <= '1;
         ld_col_q   <= '1;
         ld_base_q  <= '1;
         i_q        <= '0;
         sel_q      <= 1'b0;
         fv_q       <= 1'b0;
      end else begin
         i_q <= i_d;
         if (load_tgt) begin
            tgt_col_q  <= bus.col_in;
            tgt_base_q <= bus.frame_base;
         end
         if (swap) begin
            sel_q     <= ~sel_q;
            fv_q      <= 1'b1;
            ld_col_q  <= tgt_col_q;
            ld_base_q <= tgt_base_q;
         end
      end
   end

   // Tags follow each ROM read so data lands at its own index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_v_q <= '0;
         for (int k = 0; k < ROM_LATENCY; k++)
            tag_idx_q[k] <= '0;
      end else begin
         tag_v_q[0]   <= issue;
         tag_idx_q[0] <= i_q;
         for (int k = 1; k < ROM_LATENCY; k++) begin
            tag_v_q[k]   <= tag_v_q[k-1];
            tag_idx_q[k] <= tag_idx_q[k-1];
         end
      end
   end

   linebuf_bank_ram u_ram (
      .clk     (clk),
      .rst_n   (reset_n),
      .we_i    (tag_v_q[ROM_LATENCY-1]),
      .wbank_i (~sel_q),
      .waddr_i (tag_idx_q[ROM_LATENCY-1]),
      .wdata_i (bus.rom_data),
      .rbank_i (sel_q),
      .raddr_i (bus.px_idx),
      .ren_i   (fv_q && (bus.px_idx < PX_IDX_W'(LED_COUNT))),
      .rdata_o (bus.px_data)
   );

`ifdef LINEBUF_STATS_EN
   logic [15:0] swap_cnt_q, stale_cnt_q;
   logic        stale;

   assign stale = bus.strip_sync &&
                  ((state_q == FILL) || (state_q == DRAIN));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         swap_cnt_q  <= '0;
         stale_cnt_q <= '0;
      end else begin
         if (swap && (swap_cnt_q != 16'hFFFF))
            swap_cnt_q <= swap_cnt_q + 16'd1;
         if (stale && (stale_cnt_q != 16'hFFFF))
            stale_cnt_q <= stale_cnt_q + 16'd1;
      end
   end

   assign bus.swap_count  = swap_cnt_q;
   assign bus.stale_count = stale_cnt_q;
`endif

endmodule

// File: tb/tb_column_line_buffer.sv
// Bench for column_line_buffer: cycle model plus literal checks.
module tb_column_line_buffer;
   import linebuf_pkg::*;

   localparam int N = LED_COUNT + ROM_LATENCY;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   column_line_buffer_if bus ();

   column_line_buffer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Texture ROM whose word equals its address, one cycle latency.
   always @(posedge clk)
      bus.rom_data <= DATA_W'(bus.rom_addr);

   function automatic logic [ADDR_W-1:0] addr_of(
      input logic [ADDR_W-1:0] base,
      input logic [COL_W-1:0]  col,
      input int                idx
   );
      return ADDR_W'(int'(base) + idx * TEX_WIDTH + int'(col));
   endfunction

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t",
                  name, got, want, $time);
      end
   endtask

   // Model: fill takes N edges after its start, then waits for sync.
   bit                m_busy, m_fv;
   int                m_left, m_swaps, m_stale;
   logic [COL_W-1:0]  m_tcol, m_lcol, m_fcol;
   logic [ADDR_W-1:0] m_tbase, m_lbase, m_fbase;
   logic [DATA_W-1:0] m_px;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_busy = 0; m_fv = 0; m_left = 0;
         m_swaps = 0; m_stale = 0;
         m_lcol = '1; m_lbase = '1;
         m_tcol = '1; m_tbase = '1;
         m_fcol = '0; m_fbase = '0;
         m_px = '0;
      end else begin
         if (m_fv && int'(bus.px_idx) < LED_COUNT)
            m_px = DATA_W'(addr_of(m_fbase, m_fcol, int'(bus.px_idx)));
         else
            m_px = '0;
         if (!m_busy) begin
            if (bus.col_in != m_lcol || bus.frame_base != m_lbase) begin
               m_tcol = bus.col_in; m_tbase = bus.frame_base;
               m_left = N; m_busy = 1;
            end
         end else if (m_left > 0) begin
            if (bus.strip_sync && m_stale < 16'hFFFF) m_stale++;
            m_left--;
         end else if (bus.strip_sync) begin
            m_fcol = m_tcol; m_fbase = m_tbase; m_fv = 1;
            m_lcol = m_tcol; m_lbase = m_tbase; m_busy = 0;
            if (m_swaps < 16'hFFFF) m_swaps++;
         end else if (bus.col_in != m_tcol ||
                      bus.frame_base != m_tbase) begin
            m_tcol = bus.col_in; m_tbase = bus.frame_base;
            m_left = N;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("px_data", 32'(bus.px_data), 32'(m_px));
         check("front_valid", 32'(bus.front_valid), 32'(m_fv));
         check("busy", 32'(bus.busy), 32'(m_busy));
         if (m_busy && m_left > ROM_LATENCY)
            check("rom_addr", 32'(bus.rom_addr),
                  32'(addr_of(m_tbase, m_tcol, N - m_left)));
         else
            check("rom_addr", 32'(bus.rom_addr), 32'd0);
`ifdef LINEBUF_STATS_EN
         check("swap_count", 32'(bus.swap_count), 32'(m_swaps));
         check("stale_count", 32'(bus.stale_count), 32'(m_stale));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic sync_pulse();
      step(); bus.strip_sync = 1'b1;
      step(); bus.strip_sync = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      bus.col_in = 8'd5;
      bus.frame_base = '0;
      bus.px_idx = '0;
      bus.strip_sync = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      @(negedge clk);
      check("lit_rst_busy", 32'(bus.busy), 32'd0);
      check("lit_rst_fv", 32'(bus.front_valid), 32'd0);
      check("lit_rst_px", 32'(bus.px_data), 32'd0);
      step(); reset_n = 1'b1;
      // First fill of column 5, frame 0
      step();
      @(negedge clk);
      check("lit_addr_first", 32'(bus.rom_addr), 32'd5);
      repeat (51) step();
      @(negedge clk);
      check("lit_addr_last", 32'(bus.rom_addr), 32'd13061);
      step(); step();
      @(negedge clk);
      check("lit_ready_busy", 32'(bus.busy), 32'd1);
      check("lit_ready_fv", 32'(bus.front_valid), 32'd0);
      check("lit_ready_px", 32'(bus.px_data), 32'd0);
      repeat (3) step();
      step(); bus.strip_sync = 1'b1; bus.px_idx = 6'd3;
      step(); bus.strip_sync = 1'b0;
      @(negedge clk);
      check("lit_swap_fv", 32'(bus.front_valid), 32'd1);
      step();
      @(negedge clk);
      check("lit_px3", 32'(bus.px_data), 32'd773);
      step(); bus.px_idx = 6'd60;
      step();
      @(negedge clk);
      check("lit_px60", 32'(bus.px_data), 32'd0);
      // New frame, stale sync during fill, column change mid-fill
      step(); bus.frame_base = 20'd1024; bus.px_idx = 6'd3;
      repeat (10) step();
      sync_pulse();
      repeat (4) step();
      step(); bus.col_in = 8'd6;
      repeat (60) step();
      @(negedge clk);
      check("lit_old_front", 32'(bus.px_data), 32'd773);
      repeat (70) step();
      sync_pulse();
      step();
      @(negedge clk);
      check("lit_px3_col6", 32'(bus.px_data), 32'd1798);
      // Swap and column change in the same cycle
      step(); bus.frame_base = 20'd2048;
      repeat (60) step();
      step(); bus.strip_sync = 1'b1; bus.col_in = 8'd9;
      step(); bus.strip_sync = 1'b0;
      @(negedge clk);
      check("lit_same_idle", 32'(bus.busy), 32'd0);
      step();
      @(negedge clk);
      check("lit_same_busy", 32'(bus.busy), 32'd1);
      check("lit_same_addr", 32'(bus.rom_addr), 32'd2057);
      check("lit_same_px", 32'(bus.px_data), 32'd2822);
      repeat (60) step();
      sync_pulse();
      // Frame base near the top of the address space
      step(); bus.frame_base = 20'd1048476; bus.px_idx = 6'd1;
      step();
      @(negedge clk);
      check("lit_wrap_a0", 32'(bus.rom_addr), 32'd1048485);
      step();
      @(negedge clk);
      check("lit_wrap_a1", 32'(bus.rom_addr), 32'd165);
      repeat (60) step();
      sync_pulse();
      step();
      @(negedge clk);
      check("lit_wrap_px1", 32'(bus.px_data), 32'd165);
      step(); bus.px_idx = 6'd51;
      step();
      @(negedge clk);
      check("lit_wrap_px51", 32'(bus.px_data), 32'd12965);
      // Sync while idle is ignored
      sync_pulse();
      repeat (3) step();
      @(negedge clk);
      check("lit_idle_busy", 32'(bus.busy), 32'd0);
      check("lit_idle_px", 32'(bus.px_data), 32'd12965);
`ifdef LINEBUF_STATS_EN
      check("lit_swaps", 32'(bus.swap_count), 32'd5);
      check("lit_stale", 32'(bus.stale_count), 32'd1);
`endif
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
